note_controller: RTL and testbench



---
 rtl/piano_pkg.sv | 9 +
 rtl/note_controller_if.sv | 15 +
 rtl/key_stack.sv | 62 ++++++
 rtl/note_controller.sv | 106 ++++++++++
 tb/tb_note_controller.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared scan-code constants, parser state type and default widths for note_controller
package piano_pkg;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;
    localparam int HP_W_DEFAULT = 18;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parse_state_t;
endpackage

// File: rtl/note_controller_if.sv
// note_controller_if: byte-receiver / note-decoder / speaker bundle for note_controller
//   scan_data, scan_valid : PS/2 byte and its one-cycle strobe (into the controller)
//   key_code              : top-of-stack scan code presented to the decoder
//   half_period           : registered decoder result, 0 for an unmapped key
//   speaker, note_active  : square-wave output and tone-sounding flag
interface note_controller_if #(parameter int HP_W = 18);
    logic [7:0]      scan_data;
    logic            scan_valid;
    logic [7:0]      key_code;
    logic [HP_W-1:0] half_period;
    logic            speaker;
    logic            note_active;
    modport master (output scan_data, scan_valid, half_period, input key_code, speaker, note_active);
    modport slave  (input scan_data, scan_valid, half_period, output key_code, speaker, note_active);
endinterface

// File: rtl/key_stack.sv
// key_stack: last-pressed-priority stack of held keys, index 0 is the oldest entry
//   push/remove + code : make / break request for one scan code
//   top                : most recent held code, 0 when empty
//   empty, full        : occupancy flags
module key_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         remove,
    input  logic [W-1:0] code,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  stk_q [DEPTH];
    logic [W-1:0]  stk_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, pos;
    logic          hit;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    always_comb begin
        hit = 1'b0;
        pos = '0;
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q && stk_q[i] == code) begin
                hit = 1'b1;
                pos = CW'(i);
            end
            if (CW'(i) + CW'(1) == cnt_q) top = stk_q[i];
        end
        stk_d = stk_q;
        cnt_d = cnt_q;
        if (push && !hit) begin
            if (full) begin
                // drop the oldest entry to make room on top
                for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[DEPTH-1] = code;
            end else begin
                for (int i = 0; i < DEPTH; i++) if (CW'(i) == cnt_q) stk_d[i] = code;
                cnt_d = cnt_q + CW'(1);
            end
        end else if (remove && hit) begin
            // close the gap so the relative order of the remaining keys is kept
            for (int i = 0; i < DEPTH - 1; i++) if (CW'(i) >= pos) stk_d[i] = stk_q[i+1];
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            stk_q <= stk_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/note_controller.sv
// note_controller: PS/2 make/break parser, held-key stack and square-wave tone generator
//   clk, rst_n : 100 MHz clock, asynchronous active-low reset
//   bus        : note_controller_if.slave (scan bytes in, key_code out, half_period in, speaker/note_active out)
//   NOTE_CONTROLLER_OCTAVE_EN : when defined, 1A/22 step the octave down/up instead of acting as keys
module note_controller
    import piano_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int HP_W        = HP_W_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    note_controller_if.slave bus
);
`ifdef NOTE_CONTROLLER_OCTAVE_EN
    localparam int CW = HP_W + 1;
`else
    localparam int CW = HP_W;
`endif
    parse_state_t    state_q, state_d;
    logic [HP_W-1:0] hp_q;
    logic [CW-1:0]   cnt_q, cnt_d, eff_d, eff_q;
    logic            spk_q, spk_d, act_q, act_d;
    logic            push, remove, is_oct, oct_chg, chg;
    logic            st_empty, st_full;
    key_stack #(.DEPTH(STACK_DEPTH), .W(8)) u_stack (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .remove (remove),
        .code   (bus.scan_data),
        .top    (bus.key_code),
        .empty  (st_empty),
        .full   (st_full)
    );
`ifdef NOTE_CONTROLLER_OCTAVE_EN
    // octave encoding: 0 = down, 1 = normal, 2 = up
    logic [1:0] oct_q, oct_d;
    function automatic logic [CW-1:0] scale(input logic [HP_W-1:0] hp, input logic [1:0] oct);
        return oct == 2'd0 ? {hp, 1'b0} : oct == 2'd2 ? {2'b00, hp[HP_W-1:1]} : {1'b0, hp};
    endfunction
    assign is_oct = bus.scan_data == SC_OCT_DN || bus.scan_data == SC_OCT_UP;
    always_comb begin
        oct_d = oct_q;
        if (bus.scan_valid && state_q == IDLE && bus.scan_data == SC_OCT_DN && oct_q != 2'd0) oct_d = oct_q - 2'd1;
        if (bus.scan_valid && state_q == IDLE && bus.scan_data == SC_OCT_UP && oct_q != 2'd2) oct_d = oct_q + 2'd1;
    end
    assign oct_chg = oct_d != oct_q;
    assign eff_d   = scale(bus.half_period, oct_d);
    assign eff_q   = scale(hp_q, oct_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oct_q <= 2'd1;
        else        oct_q <= oct_d;
    end
`else
    assign is_oct  = 1'b0;
    assign oct_chg = 1'b0;
    assign eff_d   = bus.half_period;
    assign eff_q   = hp_q;
`endif
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        remove  = 1'b0;
        if (bus.scan_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = bus.scan_data == SC_BREAK ? BRK : bus.scan_data == SC_EXT ? EXT : IDLE;
                    push    = bus.scan_data != SC_BREAK && bus.scan_data != SC_EXT && !is_oct;
                end
                BRK: begin
                    state_d = IDLE;
                    remove  = !is_oct;
                end
                EXT:     state_d = bus.scan_data == SC_BREAK ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    // a new period is detected as it is captured, so the reload lands on the same edge as hp_q
    assign chg = bus.half_period != hp_q || oct_chg;
    always_comb begin
        cnt_d = chg ? (eff_d == '0 ? '0 : eff_d - CW'(1)) :
                eff_q == '0 ? '0 :
                cnt_q == '0 ? eff_q - CW'(1) : cnt_q - CW'(1);
        spk_d = !chg && eff_q != '0 && (cnt_q == '0 ? !spk_q : spk_q);
        act_d = chg ? eff_d != '0 : eff_q != '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hp_q    <= '0;
            cnt_q   <= '0;
            spk_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= bus.half_period;
            cnt_q   <= cnt_d;
            spk_q   <= spk_d;
            act_q   <= act_d;
        end
    end
    assign bus.speaker     = spk_q;
    assign bus.note_active = act_q;
endmodule

// File: tb/tb_note_controller.sv
// tb_note_controller: directed self-checking bench for note_controller with a registered decoder model
module tb_note_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    note_controller_if #(.HP_W(18)) bus ();
    note_controller #(.STACK_DEPTH(4), .HP_W(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    function automatic logic [17:0] decode(input logic [7:0] k);
        case (k)
            8'h1C:   return 18'd5;
            8'h1B:   return 18'd3;
            8'h1D:   return 18'd4;
            8'h23:   return 18'd6;
            8'h24:   return 18'd7;
            8'h15:   return 18'd1;
            default: return 18'd0;
        endcase
    endfunction
    always @(posedge clk or negedge rst_n)
        if (!rst_n) bus.half_period <= '0;
        else        bus.half_period <= decode(bus.key_code);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.scan_data  = b;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask
    initial begin
        bus.scan_data  = 8'h00;
        bus.scan_valid = 1'b0;
        tick(2);
        chk("rst_key", {24'd0, bus.key_code}, 32'h00);
        chk("rst_spk", {31'd0, bus.speaker}, 32'd0);
        chk("rst_act", {31'd0, bus.note_active}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        send(8'h1C);
        chk("make_key", {24'd0, bus.key_code}, 32'h1C);
        tick(1);
        chk("lat_act0", {31'd0, bus.note_active}, 32'd0);
        tick(1);
        chk("lat_act1", {31'd0, bus.note_active}, 32'd1);
        chk("lat_spk0", {31'd0, bus.speaker}, 32'd0);
        tick(4);
        chk("hp5_spk_m4", {31'd0, bus.speaker}, 32'd0);
        tick(1);
        chk("hp5_spk_m5", {31'd0, bus.speaker}, 32'd1);
        tick(4);
        chk("hp5_spk_m9", {31'd0, bus.speaker}, 32'd1);
        tick(1);
        chk("hp5_spk_m10", {31'd0, bus.speaker}, 32'd0);
        send(8'h1B);
        chk("push_1b_key", {24'd0, bus.key_code}, 32'h1B);
        tick(2);
        chk("hp3_spk_m0", {31'd0, bus.speaker}, 32'd0);
        chk("hp3_act", {31'd0, bus.note_active}, 32'd1);
        tick(3);
        chk("hp3_spk_m3", {31'd0, bus.speaker}, 32'd1);
        send(8'hF0);
        send(8'h1B);
        chk("fallback_key", {24'd0, bus.key_code}, 32'h1C);
        tick(2);
        chk("fallback_spk", {31'd0, bus.speaker}, 32'd0);
        chk("fallback_act", {31'd0, bus.note_active}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            send(8'h1C);
            chk("typematic_key", {24'd0, bus.key_code}, 32'h1C);
        end
        chk("typematic_spk_m20", {31'd0, bus.speaker}, 32'd0);
        tick(5);
        chk("typematic_spk_m25", {31'd0, bus.speaker}, 32'd1);
        send(8'hF0);
        send(8'h1C);
        chk("release_key", {24'd0, bus.key_code}, 32'h00);
        tick(2);
        chk("release_spk", {31'd0, bus.speaker}, 32'd0);
        chk("release_act", {31'd0, bus.note_active}, 32'd0);
        send(8'h1C);
        send(8'h1D);
        send(8'h1B);
        send(8'h23);
        send(8'h24);
        chk("full_top", {24'd0, bus.key_code}, 32'h24);
        send(8'hF0); send(8'h24);
        chk("pop_24", {24'd0, bus.key_code}, 32'h23);
        send(8'hF0); send(8'h23);
        chk("pop_23", {24'd0, bus.key_code}, 32'h1B);
        send(8'hF0); send(8'h1B);
        chk("pop_1b", {24'd0, bus.key_code}, 32'h1D);
        send(8'hF0); send(8'h1D);
        chk("pop_1d_oldest_dropped", {24'd0, bus.key_code}, 32'h00);
        send(8'h1C);
        send(8'hE0); send(8'h75);
        chk("ext_make_key", {24'd0, bus.key_code}, 32'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_break_key", {24'd0, bus.key_code}, 32'h1C);
        send(8'h16);
        chk("unmapped_key", {24'd0, bus.key_code}, 32'h16);
        tick(2);
        chk("unmapped_spk", {31'd0, bus.speaker}, 32'd0);
        chk("unmapped_act", {31'd0, bus.note_active}, 32'd0);
        send(8'hF0); send(8'h16);
        chk("unmapped_release", {24'd0, bus.key_code}, 32'h1C);
        tick(2);
        chk("pre_reset_act", {31'd0, bus.note_active}, 32'd1);
        send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_key", {24'd0, bus.key_code}, 32'h00);
        chk("async_rst_spk", {31'd0, bus.speaker}, 32'd0);
        chk("async_rst_act", {31'd0, bus.note_active}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        send(8'h1C);
        chk("post_rst_make", {24'd0, bus.key_code}, 32'h1C);
        tick(2);
        chk("post_rst_act", {31'd0, bus.note_active}, 32'd1);
        send(8'h15);
        chk("hp1_key", {24'd0, bus.key_code}, 32'h15);
        tick(2);
        chk("hp1_spk_m0", {31'd0, bus.speaker}, 32'd0);
        chk("hp1_act", {31'd0, bus.note_active}, 32'd1);
        tick(1);
        chk("hp1_spk_m1", {31'd0, bus.speaker}, 32'd1);
        tick(1);
        chk("hp1_spk_m2", {31'd0, bus.speaker}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
